arp_rx_parser: RTL and testbench
================================

# arp_rx_parser

Receive-side ARP parser sitting directly downstream of the frame splitter's ARP output. Consumes the ARP payload byte stream (Ethernet header already stripped), checks the fixed header fields and the target protocol address against `LOCAL_IP`, and emits one sender MAC/IP record per accepted packet. Each record is tagged request or reply for the ARP transmit and cache logic. All malformed, runt or foreign packets are consumed and silently dropped.

## Interface
- `LOCAL_IP`, default 32'hC0A8_006E: local IPv4 address, compared against TPA.
- `LOCAL_MAC`, default 48'hABCD_1234_5678: local MAC. Not used for filtering; exported only for the `ARP_RX_GRATUITOUS_EN` self-check.
- `logic_clk`  in  1  single clock for the block.
- `logic_rstn`  in  1  asynchronous, active-low reset.
- `arp_rdata_in`  in  8  ARP payload byte, network order.
- `arp_rvalid_in`  in  1  byte valid.
- `arp_rready_out`  out  1  parser can accept a byte.
- `arp_rlast_in`  in  1  last byte of the frame, including any pad bytes.
- `arp_res_valid_out`  out  1  record valid.
- `arp_res_ready_in`  in  1  consumer accepts the record.
- `arp_res_op_out`  out  1  1 = request (a reply is owed), 0 = reply or cache update.
- `arp_res_mac_out`  out  48  sender hardware address (SHA).
- `arp_res_ip_out`  out  32  sender protocol address (SPA).

## Operation
- A byte transfers when `arp_rvalid_in & arp_rready_out`. `arp_rlast_in` is sampled only on a transfer.
- Byte counter `cnt` is 5 bits. It increments on each transfer and saturates at 28.
- Byte map:
  - 0-1 HTYPE, must be 16'h0001.
  - 2-3 PTYPE, must be 16'h0800.
  - 4 HLEN, must be 6.
  - 5 PLEN, must be 4.
  - 6-7 OPER, must be 1 or 2.
  - 8-13 SHA, shifted into the MAC register, MSB first.
  - 14-17 SPA.
  - 18-23 THA, ignored.
  - 24-27 TPA, compared against `LOCAL_IP`.
  - Bytes 28 and above are padding and are discarded.
- A sticky `bad` flag is set on any field mismatch at its byte. `bad` is cleared only in IDLE.
- States:
  - IDLE: ready=1. The first transfer goes to RECV with cnt=1. If that first byte also has last, the packet is a runt: drop it and stay in IDLE.
  - RECV: ready=1. Capture and check fields. A transfer with last and cnt<27 is a runt: go to IDLE, no record. A transfer with last at cnt==27 goes to OUT if !bad, else IDLE. Transfer of byte 27 without last goes to DRAIN.
  - DRAIN: ready=1. Discard bytes. A transfer with last goes to OUT if !bad, else IDLE. No length limit.
  - OUT: ready=0, `arp_res_valid_out`=1, fields stable. On `arp_res_ready_in`, go to IDLE.
- Only one record is held. Upstream is back-pressured while OUT waits.
- Pad bytes never affect `bad`.

## Timing
- Reset values:
  - `arp_rready_out`=0 while reset is asserted, then 1 (IDLE) from the first clock edge after release.
  - `arp_res_valid_out`=0, `arp_res_op_out`=0, `arp_res_mac_out`=0, `arp_res_ip_out`=0.
  - State IDLE, cnt=0, `bad`=0.
- `arp_rready_out` is a registered decode of the state, not combinational from any input.
- `arp_res_valid_out` rises on the edge that accepts the last byte of a good packet, so it is high in the following cycle.
- Record handshake completes in the cycle where valid & ready are both high. `arp_rready_out`=1 in the next cycle; minimum 1 bubble between packets.
- Output fields are registered and change only while `arp_res_valid_out`=0.
- Reset asserted mid-packet or mid-OUT: everything clears immediately. The remainder of the interrupted frame is parsed as a new packet and fails the header checks or the runt check.

## Configuration
- `ARP_RX_GRATUITOUS_EN` defined:
  - A packet with SPA==TPA (gratuitous ARP) is accepted as op=0 even when TPA!=`LOCAL_IP`.
  - The exception does not apply when SHA==`LOCAL_MAC`; such packets are dropped (own echo).
- `ARP_RX_GRATUITOUS_EN` undefined: TPA must equal `LOCAL_IP`, with no exceptions.

## Test plan
- Request for 192.168.0.110 from SHA 11:22:33:44:55:66 / SPA 192.168.0.5, 28 bytes, last on byte 27 -> one record with op=1, mac=48'h112233445566, ip=32'hC0A80005, valid high 1 cycle after the last transfer.
- Same request as a 46-byte padded reply (OPER=2), with consumer ready held low 10 cycles -> `arp_rready_out`=0 for those cycles, record op=0 held stable, then released.
- TPA=192.168.0.111 -> all bytes accepted, no record. With `ARP_RX_GRATUITOUS_EN` and SPA=TPA=192.168.0.111 -> op=0 record.
- PTYPE=16'h86DD or OPER=3 -> frame drained, no record, next good packet parsed correctly.
- Runt: last on byte 20 -> no record, state IDLE. Single-byte frame with last -> no record.
- Reset pulse at byte 15 while valid stays high -> outputs zero, no record for the truncated frame.

Source files
------------

// File: rtl/arp_rx_parser.sv
// -----------------------------------------------------------------------------
// arp_rx_parser
//
// Receive-side ARP parser. Consumes the ARP payload byte stream (Ethernet
// header already removed). It checks the fixed header fields and compares the
// target protocol address with LOCAL_IP. For each accepted packet it emits one
// sender MAC/IP record, tagged as request or reply. Malformed, runt and foreign
// packets are consumed and dropped without any indication.
//
// Optional feature macro: ARP_RX_GRATUITOUS_EN
//   When defined, a gratuitous ARP (SPA == TPA) is accepted as op=0 even if
//   TPA != LOCAL_IP. Gratuitous packets whose SHA == LOCAL_MAC are still dropped,
//   because they are an echo of our own announcement.
//
// Parameters:
//   LOCAL_IP   local IPv4 address, compared with TPA
//   LOCAL_MAC  local MAC, used only for the gratuitous own-echo check
//
// Ports:
//   logic_clk          clock
//   logic_rstn         asynchronous active-low reset
//   arp_rdata_in       payload byte, network order
//   arp_rvalid_in      byte valid
//   arp_rready_out     parser can accept a byte (registered)
//   arp_rlast_in       last byte of the frame (pad included)
//   arp_res_valid_out  record valid
//   arp_res_ready_in   consumer takes the record
//   arp_res_op_out     1 = request (reply owed), 0 = reply / cache update
//   arp_res_mac_out    sender hardware address
//   arp_res_ip_out     sender protocol address
// -----------------------------------------------------------------------------
module arp_rx_parser #(
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678
) (
  input  logic        logic_clk,
  input  logic        logic_rstn,
  input  logic [7:0]  arp_rdata_in,
  input  logic        arp_rvalid_in,
  output logic        arp_rready_out,
  input  logic        arp_rlast_in,
  output logic        arp_res_valid_out,
  input  logic        arp_res_ready_in,
  output logic        arp_res_op_out,
  output logic [47:0] arp_res_mac_out,
  output logic [31:0] arp_res_ip_out
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, OUT} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        bad;       // sticky header-field mismatch
  logic        tpa_bad;   // TPA differs from LOCAL_IP
  logic        req;       // OPER was 1
  logic [47:0] mac;
  logic [31:0] ip;
  logic        ready;
  logic        res_valid;
  logic        res_op;

  logic        xfer;
  logic        fresh;
  logic [4:0]  idx;
  logic [4:0]  cnt_inc;
  logic        bad_next;
  logic        tpa_bad_next;
  logic        req_next;
  logic [47:0] mac_next;
  logic [31:0] ip_next;
  logic        accept;
  logic        op_final;

  // Select one byte of a 32-bit word, with byte 0 as the MSB (network order).
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
    logic [7:0] b;
    case (s)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign xfer  = arp_rvalid_in & ready;
  assign fresh = (state == IDLE);
  // cnt may still hold a stale value in the first IDLE cycle after OUT or a
  // runt. A byte taken in IDLE is therefore always treated as byte 0.
  assign idx     = fresh ? 5'd0 : cnt;
  assign cnt_inc = (cnt == 5'd28) ? 5'd28 : cnt + 5'd1;

`ifdef ARP_RX_GRATUITOUS_EN
  logic grat_bad;       // SPA differs from TPA
  logic grat_bad_next;
`else
  // LOCAL_MAC only matters for the gratuitous own-echo check.
  logic unused_local_mac;
  assign unused_local_mac = ^LOCAL_MAC;
`endif

  always_comb begin
    bad_next     = fresh ? 1'b0 : bad;
    tpa_bad_next = fresh ? 1'b0 : tpa_bad;
    req_next     = req;
    mac_next     = mac;
    ip_next      = ip;
`ifdef ARP_RX_GRATUITOUS_EN
    grat_bad_next = fresh ? 1'b0 : grat_bad;
`endif
    if (xfer) begin
      case (idx)
        5'd0: if (arp_rdata_in != 8'h00) bad_next = 1'b1;
        5'd1: if (arp_rdata_in != 8'h01) bad_next = 1'b1;
        5'd2: if (arp_rdata_in != 8'h08) bad_next = 1'b1;
        5'd3: if (arp_rdata_in != 8'h00) bad_next = 1'b1;
        5'd4: if (arp_rdata_in != 8'h06) bad_next = 1'b1;
        5'd5: if (arp_rdata_in != 8'h04) bad_next = 1'b1;
        5'd6: if (arp_rdata_in != 8'h00) bad_next = 1'b1;
        5'd7: begin
          if (arp_rdata_in != 8'h01 && arp_rdata_in != 8'h02) bad_next = 1'b1;
          req_next = (arp_rdata_in == 8'h01);
        end
        5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13:
          mac_next = {mac[39:0], arp_rdata_in};
        5'd14, 5'd15, 5'd16, 5'd17:
          ip_next = {ip[23:0], arp_rdata_in};
        5'd24, 5'd25, 5'd26, 5'd27: begin
          if (arp_rdata_in != byte_of(LOCAL_IP, idx[1:0])) tpa_bad_next = 1'b1;
`ifdef ARP_RX_GRATUITOUS_EN
          if (arp_rdata_in != byte_of(ip, idx[1:0])) grat_bad_next = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef ARP_RX_GRATUITOUS_EN
  assign accept   = !bad_next &&
                    (!tpa_bad_next || (!grat_bad_next && (mac != LOCAL_MAC)));
  // A packet accepted only through the gratuitous exception is a cache update.
  assign op_final = req_next & !tpa_bad_next;
`else
  assign accept   = !bad_next && !tpa_bad_next;
  assign op_final = req_next;
`endif

  always_ff @(posedge logic_clk or negedge logic_rstn) begin
    if (!logic_rstn) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      bad       <= 1'b0;
      tpa_bad   <= 1'b0;
`ifdef ARP_RX_GRATUITOUS_EN
      grat_bad  <= 1'b0;
`endif
      req       <= 1'b0;
      mac       <= 48'd0;
      ip        <= 32'd0;
      ready     <= 1'b0;
      res_valid <= 1'b0;
      res_op    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready   <= 1'b1;
          cnt     <= 5'd0;
          bad     <= 1'b0;
          tpa_bad <= 1'b0;
`ifdef ARP_RX_GRATUITOUS_EN
          grat_bad <= 1'b0;
`endif
          // A first byte that is also last is a runt. Stay in IDLE.
          if (xfer && !arp_rlast_in) begin
            state <= RECV;
            cnt   <= 5'd1;
            bad   <= bad_next;
          end
        end
        RECV: begin
          if (xfer) begin
            cnt     <= cnt_inc;
            bad     <= bad_next;
            tpa_bad <= tpa_bad_next;
`ifdef ARP_RX_GRATUITOUS_EN
            grat_bad <= grat_bad_next;
`endif
            req     <= req_next;
            mac     <= mac_next;
            ip      <= ip_next;
            if (arp_rlast_in) begin
              if (cnt == 5'd27 && accept) begin
                state     <= OUT;
                ready     <= 1'b0;
                res_valid <= 1'b1;
                res_op    <= op_final;
              end else begin
                state <= IDLE;
                cnt   <= 5'd0;
              end
            end else if (cnt == 5'd27) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Pad bytes: idx is 28 here, so the flags do not change.
          if (xfer && arp_rlast_in) begin
            if (accept) begin
              state     <= OUT;
              ready     <= 1'b0;
              res_valid <= 1'b1;
              res_op    <= op_final;
            end else begin
              state <= IDLE;
              cnt   <= 5'd0;
            end
          end
        end
        OUT: begin
          if (arp_res_ready_in) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            ready     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arp_rready_out    = ready;
  assign arp_res_valid_out = res_valid;
  assign arp_res_op_out    = res_op;
  assign arp_res_mac_out   = mac;
  assign arp_res_ip_out    = ip;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Testbench for arp_rx_parser: table-driven packets with a record scoreboard,
// plus hand-written reset, back-pressure and mid-packet reset sequences.
module tb_arp_rx_parser;

  localparam logic [31:0] LIP  = 32'hC0A8_006E;
  localparam logic [47:0] LMAC = 48'hABCD_1234_5678;
`ifdef ARP_RX_GRATUITOUS_EN
  localparam bit GRAT = 1'b1;
`else
  localparam bit GRAT = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic        res_valid;
  logic        res_ready;
  logic        res_op;
  logic [47:0] res_mac;
  logic [31:0] res_ip;

  arp_rx_parser #(.LOCAL_IP(LIP), .LOCAL_MAC(LMAC)) dut (
    .logic_clk         (clk),
    .logic_rstn        (rstn),
    .arp_rdata_in      (rdata),
    .arp_rvalid_in     (rvalid),
    .arp_rready_out    (rready),
    .arp_rlast_in      (rlast),
    .arp_res_valid_out (res_valid),
    .arp_res_ready_in  (res_ready),
    .arp_res_op_out    (res_op),
    .arp_res_mac_out   (res_mac),
    .arp_res_ip_out    (res_ip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    int          len;
    bit          expect_rec;
    bit          exp_op;
  } vec_t;

  typedef struct packed {
    logic        op;
    logic [47:0] mac;
    logic [31:0] ip;
  } rec_t;

  rec_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input vec_t v, input int i);
    logic [223:0] hdr;
    hdr = {v.htype, v.ptype, 8'd6, 8'd4, v.oper, v.sha, v.spa, 48'hFFFF_FFFF_FFFF, v.tpa};
    if (i < 28) return hdr[223 - 8*i -: 8];
    return 8'hA5;  // nonzero padding must be ignored
  endfunction

  // Presents one byte and returns 1 ns after the edge that accepted it.
  task automatic send_byte(input logic [7:0] d, input bit l);
    int waitc;
    waitc  = 0;
    rdata  = d;
    rvalid = 1'b1;
    rlast  = l;
    @(negedge clk);
    while (!rready) begin
      waitc++;
      if (waitc > 200) begin
        tests_run++;
        tests_failed++;
        $display("FAIL ready_timeout: rready stayed %0b, required 1", rready);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic send_pkt(input vec_t v);
    if (v.expect_rec) exp_q.push_back({v.exp_op, v.sha, v.spa});
    for (int i = 0; i < v.len; i++) send_byte(pkt_byte(v, i), i == v.len - 1);
    check("valid_latency", res_valid, v.expect_rec);
  endtask

  task automatic settle_check(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, {rready, 24'(exp_q.size())}, {1'b1, 24'd0});
  endtask

  // Scoreboard: pops the expected record whenever a handshake is pending.
  always @(negedge clk) begin
    if (rstn && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_record: got op=%0b mac=%h ip=%h, required none",
                 res_op, res_mac, res_ip);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        $display("[TB] record op=%0b mac=%h ip=%h", res_op, res_mac, res_ip);
        check("record", {res_op, res_mac, res_ip}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [47:0] SHA1 = 48'h1122_3344_5566;
  localparam logic [47:0] SHA2 = 48'h0A0B_0C0D_0E0F;
  localparam logic [31:0] SPA1 = 32'hC0A8_0005;
  localparam logic [31:0] IP111 = 32'hC0A8_006F;

  vec_t vecs[12];
  vec_t v;

  initial begin
    vecs[0]  = '{16'h0001, 16'h0800, 16'd1, SHA1, SPA1, LIP, 28, 1'b1, 1'b1};
    vecs[1]  = '{16'h0001, 16'h0800, 16'd2, SHA1, SPA1, LIP, 46, 1'b1, 1'b0};
    vecs[2]  = '{16'h0001, 16'h0800, 16'd1, SHA1, SPA1, IP111, 28, 1'b0, 1'b0};
    vecs[3]  = '{16'h0001, 16'h0800, 16'd1, SHA2, IP111, IP111, 28, GRAT, 1'b0};
    vecs[4]  = '{16'h0001, 16'h86DD, 16'd1, SHA1, SPA1, LIP, 28, 1'b0, 1'b0};
    vecs[5]  = '{16'h0001, 16'h0800, 16'd3, SHA1, SPA1, LIP, 40, 1'b0, 1'b0};
    vecs[6]  = '{16'h0001, 16'h0800, 16'd1, SHA2, 32'hC0A8_0101, LIP, 28, 1'b1, 1'b1};
    vecs[7]  = '{16'h0001, 16'h0800, 16'd1, SHA1, SPA1, LIP, 21, 1'b0, 1'b0};
    vecs[8]  = '{16'h0001, 16'h0800, 16'd1, SHA1, SPA1, LIP, 1, 1'b0, 1'b0};
    vecs[9]  = '{16'h0002, 16'h0800, 16'd1, SHA1, SPA1, LIP, 28, 1'b0, 1'b0};
    vecs[10] = '{16'h0001, 16'h0800, 16'd2, SHA2, 32'h0A00_0001, LIP, 60, 1'b1, 1'b0};
    vecs[11] = '{16'h0001, 16'h0800, 16'd1, LMAC, IP111, IP111, 28, 1'b0, 1'b0};

    rstn      = 1'b0;
    rdata     = 8'h00;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    res_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {rready, res_valid, res_op, res_mac, res_ip}, '0);
    rstn = 1'b1;
    #1;
    check("ready_before_edge", rready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_edge", rready, 1'b1);
    $display("[TB] reset released");

    // Table-driven packets
    for (int k = 0; k < 12; k++) begin
      $display("[TB] vector %0d len=%0d expect_record=%0b", k, vecs[k].len, vecs[k].expect_rec);
      send_pkt(vecs[k]);
      settle_check("settle");
    end

    // Back-pressure: padded reply held for 10 cycles
    $display("[TB] stall sequence");
    res_ready = 1'b0;
    send_pkt(vecs[1]);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_hold", {rready, res_valid, res_op, res_mac, res_ip},
            {1'b0, 1'b1, 1'b0, SHA1, SPA1});
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release", {rready, res_valid}, 2'b10);
    settle_check("stall_settle");

    // Reset pulse at byte 15 with valid still asserted
    $display("[TB] mid-packet reset sequence");
    v = vecs[0];
    for (int i = 0; i < 15; i++) send_byte(pkt_byte(v, i), 1'b0);
    rdata  = pkt_byte(v, 15);
    rvalid = 1'b1;
    rlast  = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("reset_mid_packet", {rready, res_valid, res_op, res_mac, res_ip}, '0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 15; i < 28; i++) send_byte(pkt_byte(v, i), i == 27);
    check("truncated_no_record", res_valid, 1'b0);
    settle_check("truncated_settle");

    // A good packet after all of that is still parsed
    $display("[TB] recovery packet");
    send_pkt(vecs[6]);
    settle_check("recovery_settle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
